rr_mux_arbiter: RTL and testbench
=================================

RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter W, default 8, data width.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port req_vld, input, N_REQ, per-requester valid.
REQ-006 SHALL have port req_data, input, N_REQ x W, per-requester data.
REQ-007 SHALL have port req_rdy, output, N_REQ, per-requester ready; one-hot or zero.
REQ-008 SHALL have port out_vld, output, 1, output data valid.
REQ-009 SHALL have port out_data, output, W, registered output data.
REQ-010 SHALL have port out_rdy, input, 1, downstream ready.
REQ-011 SHALL have port out_sel, output, $clog2(N_REQ), index of requester whose beat sits in out_data.

Function
REQ-012 SHALL transfer a beat on any interface when vld and rdy are both high at a rising edge.
REQ-013 SHALL treat the output stage as a one-entry register; "slot free" = !out_vld or (out_vld and out_rdy).
REQ-014 SHALL, when slot free and any req_vld high, combinationally assert req_rdy for exactly one requester, the first valid one searching upward from (last_grant+1) mod N_REQ with wrap-around.
REQ-015 SHALL keep req_rdy all-zero when slot not free or no req_vld high.
REQ-016 SHALL on an accepted request load out_data, out_sel and last_grant in the same edge and set out_vld next cycle (latency 1 cycle).
REQ-017 SHALL sustain one beat per cycle when out_rdy held high (no bubbles under continuous requests).
REQ-018 SHALL clear out_vld on an output transfer with no simultaneous accepted request.
REQ-019 SHALL hold out_vld, out_data, out_sel stable while out_vld and !out_rdy.
REQ-020 SHALL give a single active requester every slot (no forced rotation to idle requesters).
REQ-021 SHALL guarantee each continuously-valid requester a grant within N_REQ accepted beats.
REQ-022 SHALL implement two-state FSM: EMPTY (out_vld=0) and FULL (out_vld=1); EMPTY->FULL on accept; FULL->EMPTY on output transfer without accept; FULL->FULL on stall or on transfer+accept.
REQ-023 SHALL not combinationally depend req_rdy on req_data.

Reset
REQ-024 SHALL on rst: out_vld=0, FSM=EMPTY, out_data=0, out_sel=0, last_grant=N_REQ-1 (so requester 0 has first priority).
REQ-025 SHALL drop any beat held in the output register when rst asserts mid-operation; req_rdy=0 while rst high.

Configuration
REQ-026 SHALL, with RR_MUX_ARBITER_GRANT_CNT_EN defined, add output grant_cnt (N_REQ x 16), per-requester count of accepted beats, cleared on rst, saturating at 16'hFFFF.
REQ-027 SHALL, without RR_MUX_ARBITER_GRANT_CNT_EN, have no grant_cnt port and no counter logic; all other behaviour identical.

Structure
REQ-028 SHALL place FSM state enum (ST_EMPTY, ST_FULL) and counter width constant GRANT_CNT_W=16 in package rr_mux_arbiter_pkg.
REQ-029 SHALL use one sub-module rr_pick (combinational round-robin picker: req vector + last_grant -> one-hot grant + index); the data path SHALL select req_data with the picker index as a mux.

Verification
REQ-030 Reset: rst high 2 cycles, req_vld=4'b1111 -> req_rdy=0, out_vld=0; first cycle after rst -> req_rdy=4'b0001.
REQ-031 Rotation: req_vld=4'b1111, data i=8'hA0+i, out_rdy=1 -> out_sel sequence 0,1,2,3,0, out_data A0,A1,A2,A3,A0, out_vld continuously high.
REQ-032 Skip/wrap: last_grant=2, req_vld=4'b0011 -> grant requester 0, then 1, then 0.
REQ-033 Backpressure: out_vld=1 holding 8'h55, out_rdy=0 for 3 cycles with req_vld=4'b0100 -> req_rdy=0, out_data stays 55; out_rdy=1 -> same edge accepts requester 2, next cycle out_sel=2.
REQ-034 Mid-op reset: out_vld=1, out_rdy=0, rst pulse 1 cycle -> out_vld=0 next cycle, held beat never transferred.
REQ-035 With RR_MUX_ARBITER_GRANT_CNT_EN: 10 accepted beats from requester 1 only -> grant_cnt[1]=10, others 0; preloaded 16'hFFFE plus 3 grants -> 16'hFFFF.

Source files
------------

// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and constants for the round-robin mux arbiter.
// Optional feature macro: RR_MUX_ARBITER_GRANT_CNT_EN (per-requester grant counters).
package rr_mux_arbiter_pkg;

  // Occupancy of the one-entry output register.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } st_e;

  // Width of each per-requester accepted-beat counter.
  localparam int GRANT_CNT_W = 16;

endpackage

// File: rtl/rr_mux_arbiter_pick.sv
// Combinational round-robin picker: searches upward from last_grant+1 with
// wrap-around and returns the first requesting index as one-hot and binary.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int SW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SW-1:0]    last_grant,
  output logic [N_REQ-1:0] gnt,
  output logic [SW-1:0]    idx
);

  // Rotating priority search; the requester just served is checked last.
  always_comb begin
    int  cand;
    logic found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (int'(last_grant) + k) % N_REQ;
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = SW'(cand);
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin N:1 arbiter with a one-entry registered output stage.
// Optional feature macro: RR_MUX_ARBITER_GRANT_CNT_EN adds the grant_cnt
// output (saturating per-requester count of accepted beats).
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_vld,
  input  logic [N_REQ*W-1:0]         req_data,
  output logic [N_REQ-1:0]           req_rdy,
  output logic                       out_vld,
  output logic [W-1:0]               out_data,
  input  logic                       out_rdy,
  output logic [$clog2(N_REQ)-1:0]   out_sel
`ifdef RR_MUX_ARBITER_GRANT_CNT_EN
  ,
  output logic [N_REQ*GRANT_CNT_W-1:0] grant_cnt
`endif
);

  localparam int SW = $clog2(N_REQ);

  st_e               st_p0, st_nxt;
  logic [SW-1:0]     last_grant_p0;
  logic [N_REQ-1:0]  pick_gnt;
  logic [SW-1:0]     pick_idx;
  logic [W-1:0]      mux_data;
  logic              slot_free;
  logic              accept;

  rr_pick #(
    .N_REQ (N_REQ),
    .SW    (SW)
  ) u_pick (
    .req        (req_vld),
    .last_grant (last_grant_p0),
    .gnt        (pick_gnt),
    .idx        (pick_idx)
  );

  // Handshake: grant only when the output register can take a beat and not in reset.
  always_comb begin
    slot_free = (st_p0 == ST_EMPTY) || out_rdy;
    req_rdy   = (slot_free && !rst) ? pick_gnt : '0;
    accept    = |req_rdy;
    mux_data  = req_data[int'(pick_idx)*W +: W];
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) st_p0 <= ST_EMPTY;
    else     st_p0 <= st_nxt;
  end

  // FSM next state: empty fills on accept; full drains only on transfer without refill.
  always_comb begin
    st_nxt = st_p0;
    case (st_p0)
      ST_EMPTY: if (accept) st_nxt = ST_FULL;
      ST_FULL:  if (out_rdy && !accept) st_nxt = ST_EMPTY;
      default:  st_nxt = ST_EMPTY;
    endcase
  end

  assign out_vld = (st_p0 == ST_FULL);

  // ---- stage p0 -> output register: capture granted beat and its source ----
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data      <= '0;
      out_sel       <= '0;
      last_grant_p0 <= SW'(N_REQ - 1);
    end else if (accept) begin
      out_data      <= mux_data;
      out_sel       <= pick_idx;
      last_grant_p0 <= pick_idx;
    end
  end

`ifdef RR_MUX_ARBITER_GRANT_CNT_EN
  function automatic logic [GRANT_CNT_W-1:0] sat_inc(input logic [GRANT_CNT_W-1:0] c);
    return (c == {GRANT_CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

  // Per-requester accepted-beat counters, saturating at all-ones.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (rst)
        grant_cnt[i*GRANT_CNT_W +: GRANT_CNT_W] <= '0;
      else if (req_rdy[i])
        grant_cnt[i*GRANT_CNT_W +: GRANT_CNT_W] <=
          sat_inc(grant_cnt[i*GRANT_CNT_W +: GRANT_CNT_W]);
    end
  end
`endif

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter: the driver pushes the hand-computed
// beat for every expected grant, the monitor pops on each output transfer.
module tb_rr_mux_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_vld;
  logic [31:0] req_data;
  logic [3:0]  req_rdy;
  logic        out_vld;
  logic [7:0]  out_data;
  logic        out_rdy;
  logic [1:0]  out_sel;
`ifdef RR_MUX_ARBITER_GRANT_CNT_EN
  logic [63:0] grant_cnt;
`endif

  logic [7:0]  d [4];
  logic [9:0]  sb [$];
  int tests = 0;
  int fails = 0;

  assign req_data = {d[3], d[2], d[1], d[0]};

  always #5 clk = ~clk;

  rr_mux_arbiter #(.N_REQ(4), .W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_vld  (req_vld),
    .req_data (req_data),
    .req_rdy  (req_rdy),
    .out_vld  (out_vld),
    .out_data (out_data),
    .out_rdy  (out_rdy),
    .out_sel  (out_sel)
`ifdef RR_MUX_ARBITER_GRANT_CNT_EN
    ,
    .grant_cnt(grant_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every output transfer must match the oldest expected beat.
  always @(negedge clk) begin
    if (!rst && out_vld && out_rdy) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", {22'd0, out_sel, out_data}, 32'hFFFF_FFFF);
      end else begin
        logic [9:0] e;
        e = sb.pop_front();
        chk("beat_sel", {30'd0, out_sel}, {30'd0, e[9:8]});
        chk("beat_data", {24'd0, out_data}, {24'd0, e[7:0]});
      end
    end
  end

  // One cycle: drive at posedge+1, check handshake at posedge+2, push expected beat.
  task automatic cyc(input logic [3:0] v, input logic r, input logic [3:0] er, input int ev);
    req_vld = v;
    out_rdy = r;
    #1;
    chk("req_rdy", {28'd0, req_rdy}, {28'd0, er});
    if (ev >= 0) chk("out_vld", {31'd0, out_vld}, ev[31:0]);
    for (int i = 0; i < 4; i++)
      if (er[i]) sb.push_back({i[1:0], d[i]});
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) d[i] = 8'hA0 + 8'(i);
    rst = 1'b1; req_vld = 4'b1111; out_rdy = 1'b0;

    // Reset held two cycles with all requesters valid.
    @(posedge clk); #1;
    chk("rst_req_rdy", {28'd0, req_rdy}, 32'd0);
    chk("rst_out_vld", {31'd0, out_vld}, 32'd0);
    @(posedge clk); #1;
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_out_sel", {30'd0, out_sel}, 32'd0);
    rst = 1'b0;

    // Rotation 0,1,2,3,0 with no bubbles, then drain.
    cyc(4'b1111, 1'b1, 4'b0001, 0);
    cyc(4'b1111, 1'b1, 4'b0010, 1);
    cyc(4'b1111, 1'b1, 4'b0100, 1);
    cyc(4'b1111, 1'b1, 4'b1000, 1);
    cyc(4'b1111, 1'b1, 4'b0001, 1);
    cyc(4'b0000, 1'b1, 4'b0000, 1);

    // Skip/wrap: last_grant=2, requesters 0,1 -> 0,1,0.
    cyc(4'b0100, 1'b1, 4'b0100, 0);
    cyc(4'b0011, 1'b1, 4'b0001, 1);
    cyc(4'b0011, 1'b1, 4'b0010, 1);
    cyc(4'b0011, 1'b1, 4'b0001, 1);
    cyc(4'b0000, 1'b1, 4'b0000, 1);

    // Backpressure: hold 8'h55 from requester 3 for three stalled cycles.
    d[3] = 8'h55;
    cyc(4'b1000, 1'b1, 4'b1000, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(4'b0100, 1'b0, 4'b0000, 1);
      chk("bp_hold_data", {24'd0, out_data}, 32'h55);
      chk("bp_hold_sel", {30'd0, out_sel}, 32'd3);
    end
    cyc(4'b0100, 1'b1, 4'b0100, 1);
    chk("bp_next_sel", {30'd0, out_sel}, 32'd2);
    chk("bp_next_data", {24'd0, out_data}, 32'hA2);
    cyc(4'b0000, 1'b1, 4'b0000, 1);
    d[3] = 8'hA3;

    // Lone requester 1 wins every slot.
    cyc(4'b0010, 1'b1, 4'b0010, 0);
    cyc(4'b0010, 1'b1, 4'b0010, 1);
    cyc(4'b0010, 1'b1, 4'b0010, 1);
    cyc(4'b0000, 1'b1, 4'b0000, 1);

    // Mid-operation reset drops the stalled beat.
    cyc(4'b0001, 1'b0, 4'b0001, 0);
    cyc(4'b0000, 1'b0, 4'b0000, 1);
    rst = 1'b1; req_vld = 4'b0001; #1;
    chk("midrst_req_rdy", {28'd0, req_rdy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; req_vld = 4'b0000; out_rdy = 1'b1; #1;
    chk("midrst_out_vld", {31'd0, out_vld}, 32'd0);
    chk("midrst_dropped", sb.size(), 32'd1);
    sb.delete();
    @(posedge clk); #1;
    cyc(4'b1111, 1'b1, 4'b0001, 0);
    cyc(4'b0000, 1'b1, 4'b0000, 1);
    chk("drained_vld", {31'd0, out_vld}, 32'd0);

`ifdef RR_MUX_ARBITER_GRANT_CNT_EN
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    for (int k = 0; k < 10; k++) cyc(4'b0010, 1'b1, 4'b0010, -1);
    cyc(4'b0000, 1'b1, 4'b0000, 1);
    for (int i = 0; i < 4; i++)
      chk("cnt10", {16'd0, grant_cnt[i*16 +: 16]}, (i == 1) ? 32'd10 : 32'd0);
    req_vld = 4'b0010; out_rdy = 1'b1;
    repeat (65534 - 10) begin
      sb.push_back({2'd1, d[1]});
      @(posedge clk);
    end
    #1;
    chk("cnt_fffe", {16'd0, grant_cnt[16 +: 16]}, 32'hFFFE);
    repeat (3) begin
      sb.push_back({2'd1, d[1]});
      @(posedge clk);
    end
    #1; req_vld = 4'b0000;
    @(posedge clk); #1;
    chk("cnt_sat", {16'd0, grant_cnt[16 +: 16]}, 32'hFFFF);
`endif

    chk("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
